// File: rtl/rng_xs96.sv
// -----------------------------------------------------------------------------
// rng_xs96 : iterative 96-bit xorshift pseudo-random word generator.
//
// Each accepted request runs ROUNDS xorshift steps on the persistent 96-bit
// state (one step per clock). The final state is published on data_out, and
// finish pulses for one cycle. A request may first reload the state from
// seed. An all-zero seed is replaced by DEFAULT_SEED so the state never
// locks up at zero.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - request one word (level-sampled while idle)
//   in_mod   - sampled with start: 1 = load seed first, 0 = continue stream
//   seed     - 96-bit seed, used only when start && in_mod is accepted
//   data_out - last generated word, held until the next finish
//   finish   - one-cycle pulse when a new data_out is valid
//   busy     - high while the generator is stepping
// -----------------------------------------------------------------------------
module rng_xs96 #(
    parameter int unsigned ROUNDS       = 4,
    parameter logic [95:0] DEFAULT_SEED = 96'h9E3779B9_7F4A7C15_F39CC060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_mod,
    input  logic [95:0] seed,
    output logic [95:0] data_out,
    output logic        finish,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter value seen during the final step of a request.
    localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

    // One xorshift step: x'=y, y'=z, z'=z^(z>>19)^t^(t>>8), t=x^(x<<11).
    function automatic logic [95:0] xs_step(input logic [95:0] s);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] t;
        logic [31:0] z_new;
        x     = s[95:64];
        y     = s[63:32];
        z     = s[31:0];
        t     = x ^ (x << 5'd11);
        z_new = z ^ (z >> 5'd19) ^ t ^ (t >> 5'd8);
        return {y, z, z_new};
    endfunction

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [95:0] s_q;
    logic [95:0] s_d;
    logic [95:0] data_out_q;
    logic [95:0] data_out_d;
    logic        finish_q;
    logic        finish_d;
    logic [95:0] step_s;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: round counter, generator state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 4'd0;
            s_q        <= DEFAULT_SEED;
            data_out_q <= 96'd0;
            finish_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            data_out_q <= data_out_d;
            finish_q   <= finish_d;
        end
    end

    // Next-state logic: IDLE waits for start, RUN lasts ROUNDS cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: seed load on accept, one step per RUN cycle.
    always_comb begin
        step_s     = xs_step(s_q);
        cnt_d      = cnt_q;
        s_d        = s_q;
        data_out_d = data_out_q;
        finish_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = 4'd0;
                    if (in_mod) begin
                        // A zero state is a fixed point of xorshift, so never load it.
                        if (seed == 96'd0) begin
                            s_d = DEFAULT_SEED;
                        end else begin
                            s_d = seed;
                        end
                    end else begin
                        s_d = s_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RUN: begin
                s_d = step_s;
                if (cnt_q == LAST_CNT) begin
                    // Leave the counter at zero so IDLE always holds a clean value.
                    cnt_d      = 4'd0;
                    data_out_d = step_s;
                    finish_d   = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 4'd1;
                    data_out_d = data_out_q;
                    finish_d   = 1'b0;
                end
            end
            default: begin
                cnt_d = 4'd0;
                s_d   = DEFAULT_SEED;
            end
        endcase
    end

    // Output logic: busy follows the RUN state, the rest are register copies.
    always_comb begin
        busy     = (state_q == ST_RUN);
        data_out = data_out_q;
        finish   = finish_q;
    end

endmodule

// File: tb/tb_rng_xs96.sv
module tb_rng_xs96;

    localparam logic [95:0] DEF  = 96'h9E3779B9_7F4A7C15_F39CC060;
    localparam logic [95:0] S1   = 96'h00000001_00000002_00000003;
    localparam logic [95:0] S1_1 = 96'h00000002_00000003_0000080A; // one step of S1
    localparam logic [95:0] S1_4 = 96'h00001818_00000003_00401851; // four steps of S1
    localparam logic [95:0] SA   = 96'h01234567_89ABCDEF_0F1E2D3C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_mod = 1'b0;
    logic [95:0] seed = 96'd0;
    logic [95:0] dout [2];
    logic        fin  [2];
    logic        bsy  [2];

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // behavioural model state, one slot per instance (0: ROUNDS=4, 1: ROUNDS=1)
    logic [95:0] ms     [2] = '{DEF, DEF};
    logic [95:0] pend   [2] = '{96'd0, 96'd0};
    logic [95:0] exp_d  [2] = '{96'd0, 96'd0};
    logic        exp_f  [2] = '{1'b0, 1'b0};
    int          left   [2] = '{0, 0};

    rng_xs96 #(.ROUNDS(4)) u_r4 (
        .clk(clk), .rst(rst), .start(start), .in_mod(in_mod), .seed(seed),
        .data_out(dout[0]), .finish(fin[0]), .busy(bsy[0])
    );

    rng_xs96 #(.ROUNDS(1)) u_r1 (
        .clk(clk), .rst(rst), .start(start), .in_mod(in_mod), .seed(seed),
        .data_out(dout[1]), .finish(fin[1]), .busy(bsy[1])
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] ref_step(input logic [95:0] s);
        logic [31:0] x, y, z, t, zn;
        x = s[95:64]; y = s[63:32]; z = s[31:0];
        t  = x ^ (x << 11);
        zn = z ^ (z >> 19) ^ t ^ (t >> 8);
        return {y, z, zn};
    endfunction

    function automatic logic [95:0] ref_n(input logic [95:0] s, input int n);
        logic [95:0] r;
        r = s;
        for (int k = 0; k < n; k++) r = ref_step(r);
        return r;
    endfunction

    task automatic chk96(input string nm, input logic [95:0] act, input logic [95:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, expv);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Model: a request computes its whole word at acceptance, then counts down.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ms[i] = DEF; left[i] = 0; exp_d[i] = 96'd0; exp_f[i] = 1'b0;
            end else if (left[i] == 0) begin
                exp_f[i] = 1'b0;
                if (start) begin
                    if (in_mod) ms[i] = (seed == 96'd0) ? DEF : seed;
                    ms[i]   = ref_n(ms[i], (i == 0) ? 4 : 1);
                    pend[i] = ms[i];
                    left[i] = (i == 0) ? 4 : 1;
                end
            end else begin
                left[i] = left[i] - 1;
                if (left[i] == 0) begin
                    exp_f[i] = 1'b1;
                    exp_d[i] = pend[i];
                end
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk1($sformatf("r%0d finish", i), fin[i], exp_f[i]);
                chk1($sformatf("r%0d busy", i), bsy[i], left[i] != 0);
                chk96($sformatf("r%0d data_out", i), dout[i], exp_d[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic m, input logic [95:0] sd);
        start = 1'b1; in_mod = m; seed = sd;
        tick();
        start = 1'b0; in_mod = 1'b0; seed = 96'd0;
    endtask

    task automatic wait_fin0();
        int n;
        n = 0;
        while (!fin[0] && n < 30) begin
            tick();
            n++;
        end
        chk1("finish timeout", fin[0], 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] w [4];
        int cnt0, cnt1, last, cyc;

        // pin the model against hand-computed values
        chk96("model 1 step", ref_n(S1, 1), S1_1);
        chk96("model 4 steps", ref_n(S1, 4), S1_4);

        // reset
        tick(); tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk96("reset data_out", dout[i], 96'd0);
            chk1("reset busy", bsy[i], 1'b0);
            chk1("reset finish", fin[i], 1'b0);
        end

        // single seeded request
        req(1'b1, S1);
        wait_fin0();
        chk96("r4 seeded word", dout[0], S1_4);
        chk96("r1 seeded word", dout[1], S1_1);
        tick();
        chk1("finish one cycle", fin[0], 1'b0);

        // zero seed substitutes the default seed
        req(1'b1, 96'd0);
        wait_fin0();
        chk96("r4 zero seed", dout[0], ref_n(DEF, 4));
        chk96("r1 zero seed", dout[1], ref_n(DEF, 1));

        // 1000 continuous words: never zero
        cnt0 = 0;
        start = 1'b1; in_mod = 1'b0;
        repeat (5000) begin
            tick();
            if (fin[0]) begin
                cnt0++;
                n_chk++;
                if (dout[0] == 96'd0) begin
                    n_fail++;
                    $display("FAIL nonzero word: got %h, expected nonzero", dout[0]);
                end
            end
        end
        start = 1'b0;
        chkint("1000 words", cnt0, 1000);

        // stream continuity from seed A
        req(1'b1, SA);
        wait_fin0();
        w[0] = dout[0];
        for (int k = 1; k < 4; k++) begin
            req(1'b0, 96'd0);
            wait_fin0();
            w[k] = dout[0];
        end
        for (int k = 0; k < 4; k++)
            chk96($sformatf("stream word %0d", k), w[k], ref_n(SA, 4 * (k + 1)));

        // start held 50 cycles, seed changing every cycle
        cnt0 = 0; cnt1 = 0; last = -1; cyc = 0;
        start = 1'b1; in_mod = 1'b1;
        repeat (50) begin
            seed = {$urandom, $urandom, $urandom};
            tick();
            cyc++;
            if (fin[0]) begin
                cnt0++;
                if (last >= 0) chkint("finish spacing", cyc - last, 5);
                last = cyc;
            end
            if (fin[1]) cnt1++;
        end
        start = 1'b0; in_mod = 1'b0; seed = 96'd0;
        chkint("r4 pulses in 50", cnt0, 10);
        chkint("r1 pulses in 50", cnt1, 25);
        tick(); tick();

        // reset two cycles into RUN
        req(1'b0, 96'd0);
        tick();
        rst = 1'b1;
        #1;
        chk1("abort busy", bsy[0], 1'b0);
        chk1("abort finish", fin[0], 1'b0);
        chk96("abort data_out", dout[0], 96'd0);
        tick(); tick();
        rst = 1'b0; start = 1'b1; in_mod = 1'b0;
        tick();
        start = 1'b0;
        wait_fin0();
        chk96("r4 after reset", dout[0], ref_n(DEF, 4));
        chk96("r1 after reset", dout[1], ref_n(DEF, 1));

        tick(); tick(); tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rng_xs96.md
# rng_xs96

Iterative 96-bit xorshift pseudo-random generator feeding the key-generation controller's `rng_*` interface; upstream of it in the ROLLO-I encrypt datapath. Each request produces one 96-bit word `data_out` after `ROUNDS` state-update cycles and pulses `finish`. The controller slices the upper `m` bits of that word into support-space vectors. A request can optionally reload the 96-bit state from `seed` before generating.

## Interface
- `ROUNDS`, default 4: xorshift steps per output word; legal range 1..15.
- `DEFAULT_SEED`, default 96'h9E3779B9_7F4A7C15_F39CC060: state loaded on reset and substituted for an all-zero seed.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request one word. Level-sampled in IDLE only.
- `in_mod` input 1: sampled with `start`. 1 = load `seed` before generating; 0 = continue from the current state.
- `seed` input 96: seed value, used only when `start && in_mod` is accepted.
- `data_out` output 96: last generated word; held until the next `finish`.
- `finish` output 1: one-cycle pulse; `data_out` is valid from this cycle onward.
- `busy` output 1: high while in RUN.

## Operation
- State register `s[95:0]` is split into words x=`s[95:64]`, y=`s[63:32]`, z=`s[31:0]`.
- One step computes:
  - t = x ^ (x << 11), 32-bit, shifted-out bits dropped.
  - x' = y; y' = z.
  - z' = z ^ (z >> 19) ^ t ^ (t >> 8), logical shifts, 32-bit.
- FSM states are IDLE and RUN. Round counter `cnt` is 4 bits.
- IDLE:
  - If `start`=1, go to RUN with `cnt`=0.
  - If `in_mod`=1, also load `s` <= `seed`; if `seed`==0, load `DEFAULT_SEED` instead.
  - If `start`=0, hold.
- RUN:
  - Each cycle, `s` <= step(`s`) and `cnt` <= `cnt`+1. `start`, `in_mod` and `seed` are ignored.
  - On the cycle where `cnt`==`ROUNDS`-1: apply the step, set `data_out` <= step(`s`), set `finish` <= 1, return to IDLE.
- `s` is never all-zero: a nonzero state stays nonzero under the step.
- The generator state persists between requests. With `in_mod`=0, consecutive words are a continuation of one stream.

## Timing
- Reset (async assert, released synchronously by the clock domain) sets:
  - state = IDLE, `cnt`=0, `s`=`DEFAULT_SEED`;
  - `data_out`=0, `finish`=0, `busy`=0.
- Latency: `start` is accepted at rising edge k. The steps land on edges k+1..k+`ROUNDS`. `finish`=1 and the new `data_out` are visible in the cycle after edge k+`ROUNDS`.
- `busy` is high for exactly `ROUNDS` cycles per request.
- `finish` is registered and high for exactly one cycle. It is 0 in every other cycle, including while `start` is held.
- Back-to-back requests: `start` held high continuously gives one word every `ROUNDS`+1 cycles. A `start` that is high in the `finish` cycle is accepted (FSM is in IDLE).
- Reset mid-RUN: the request is aborted, no `finish` is produced, and `s` returns to `DEFAULT_SEED`.
- `start` asserted in the same cycle that reset deasserts: not accepted until the first edge at which `rst`=0.
- `data_out` changes only on the edge that raises `finish` (and on reset).

## Test plan
- Reset, then `start`=1, `in_mod`=1, `seed`=96'h0000_0001_0000_0002_0000_0003 for one cycle, `ROUNDS`=4.
  - `busy` high for 4 cycles; `finish` is a single pulse 4 cycles after acceptance.
  - `data_out` equals the golden model's 4-step result from that seed.
- `seed`=0 with `in_mod`=1: `data_out` equals the model output seeded with `DEFAULT_SEED`. State never becomes 0 over 1000 words.
- Stream continuity:
  - Load seed A, then make 3 requests with `in_mod`=0.
  - Result must equal one 16-step run from A, sampled every 4 steps.
- Hold `start`=1 for 50 cycles with `ROUNDS`=4: exactly 10 `finish` pulses, spaced 5 cycles apart. `seed` changes during RUN have no effect.
- Assert `rst` 2 cycles into RUN: no `finish`, outputs at reset values. A subsequent `in_mod`=0 request reproduces the first `DEFAULT_SEED` word.
- `ROUNDS`=1: `finish` 1 cycle after acceptance; `data_out` equals a single step of the seed.
